// File: rtl/wshb_arbiter_if.sv
// Wishbone B4 bus bundle shared by the two internal masters and the SDRAM slave port.
// Interface name is wshb_if so it drops in for the existing wshb_if instances in Top.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [8*DATA_BYTES-1:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM slave; grant is held for a whole cyc.
// Define WSHB_ARB_RR_EN for round-robin tie-break; default is fixed priority to master 0.
//
// state | meaning
// IDLE  | no owner, slave sees an idle bus, arbitration happens here
// GNT0  | master 0 (video reader) owns the slave until it drops cyc
// GNT1  | master 1 (writer) owns the slave until it drops cyc
module wshb_arbiter #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       tie_pick1;

    logic                    fwd_cyc, fwd_stb, fwd_we;
    logic [ADDR_WIDTH-1:0]   fwd_adr;
    logic [8*DATA_BYTES-1:0] fwd_dat;
    logic [DATA_BYTES-1:0]   fwd_sel;
    logic [2:0]              fwd_cti;
    logic [1:0]              fwd_bte;

    logic route0, route1;

`ifdef WSHB_ARB_RR_EN
    // last == 1 means master 1 was served most recently, so master 0 wins the tie.
    assign tie_pick1 = ~last_q;
`else
    assign tie_pick1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
                    state_d = tie_pick1 ? GNT1 : GNT0;
                end else if (wshb_ifs0.cyc) begin
                    state_d = GNT0;
                end else if (wshb_ifs1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!wshb_ifs0.cyc) state_d = IDLE;
            end
            GNT1: begin
                if (!wshb_ifs1.cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && state_d == GNT0) last_d = 1'b0;
        if (state_q == IDLE && state_d == GNT1) last_d = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Forward path is driven straight from the state register so a reset clears it at once.
    always_comb begin
        fwd_cyc = 1'b0;
        fwd_stb = 1'b0;
        fwd_we  = 1'b0;
        fwd_adr = '0;
        fwd_dat = '0;
        fwd_sel = '0;
        fwd_cti = '0;
        fwd_bte = '0;
        unique case (state_q)
            GNT0: begin
                fwd_cyc = wshb_ifs0.cyc;
                fwd_stb = wshb_ifs0.stb;
                fwd_we  = wshb_ifs0.we;
                fwd_adr = wshb_ifs0.adr;
                fwd_dat = wshb_ifs0.dat_ms;
                fwd_sel = wshb_ifs0.sel;
                fwd_cti = wshb_ifs0.cti;
                fwd_bte = wshb_ifs0.bte;
            end
            GNT1: begin
                fwd_cyc = wshb_ifs1.cyc;
                fwd_stb = wshb_ifs1.stb;
                fwd_we  = wshb_ifs1.we;
                fwd_adr = wshb_ifs1.adr;
                fwd_dat = wshb_ifs1.dat_ms;
                fwd_sel = wshb_ifs1.sel;
                fwd_cti = wshb_ifs1.cti;
                fwd_bte = wshb_ifs1.bte;
            end
            default: ;
        endcase
    end

    assign wshb_ifm.cyc    = fwd_cyc;
    assign wshb_ifm.stb    = fwd_stb;
    assign wshb_ifm.we     = fwd_we;
    assign wshb_ifm.adr    = fwd_adr;
    assign wshb_ifm.dat_ms = fwd_dat;
    assign wshb_ifm.sel    = fwd_sel;
    assign wshb_ifm.cti    = fwd_cti;
    assign wshb_ifm.bte    = fwd_bte;

    // A response arriving while the owner has cyc low is a slave error and is dropped.
    assign route0 = (state_q == GNT0) && wshb_ifs0.cyc;
    assign route1 = (state_q == GNT1) && wshb_ifs1.cyc;

    assign wshb_ifs0.ack    = route0 & wshb_ifm.ack;
    assign wshb_ifs0.err    = route0 & wshb_ifm.err;
    assign wshb_ifs0.rty    = route0 & wshb_ifm.rty;
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;

    assign wshb_ifs1.ack    = route1 & wshb_ifm.ack;
    assign wshb_ifs1.err    = route1 & wshb_ifm.err;
    assign wshb_ifs1.rty    = route1 & wshb_ifm.rty;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

    assign gnt = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: vector table for arbitration, scoreboard for data.
module tb_wshb_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst;
    logic [1:0] gnt;

    always #5 sys_clk = ~sys_clk;

    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) m0 ();
    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) m1 ();
    wshb_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) s ();

    wshb_arbiter #(.DATA_BYTES(4), .ADDR_WIDTH(32)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wshb_ifs0 (m0),
        .wshb_ifs1 (m1),
        .wshb_ifm  (s),
        .gnt       (gnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    // Slave model: registered ack after slv_lat cycles of a pending strobe, or forced from the table.
    logic        slv_ack;
    logic [31:0] slv_dat;
    int          slv_cnt;
    int          slv_lat = 3;
    logic        force_mode = 1'b0;
    logic        tb_ack = 1'b0;

    assign s.ack    = force_mode ? tb_ack : slv_ack;
    assign s.err    = 1'b0;
    assign s.rty    = 1'b0;
    assign s.dat_sm = slv_dat;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFEF00D;
        return {a[15:0], 16'hBEEF};
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slv_ack <= 1'b0;
            slv_cnt <= 0;
            slv_dat <= '0;
        end else begin
            slv_ack <= 1'b0;
            if (s.cyc && s.stb && !slv_ack) begin
                if (slv_cnt >= slv_lat - 1) begin
                    slv_ack <= 1'b1;
                    slv_dat <= data_for(s.adr);
                    slv_cnt <= 0;
                end else begin
                    slv_cnt <= slv_cnt + 1;
                end
            end else begin
                slv_cnt <= 0;
            end
        end
    end

    typedef struct {
        logic       c0;
        logic       c1;
        logic       ack;
        logic [4:0] exp;   // {gnt, slave cyc, m0 ack, m1 ack}
    } vec_t;
    vec_t vt[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (sb_q.size() == 0) return 32'hDEADDEAD;
        return sb_q.pop_front();
    endfunction

    task automatic drive(input int m, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
        if (m == 0) begin
            m0.cyc = cyc; m0.stb = cyc; m0.we = 1'b0; m0.adr = adr;
            m0.dat_ms = '0; m0.sel = 4'hF; m0.cti = cti; m0.bte = 2'b00;
        end else begin
            m1.cyc = cyc; m1.stb = cyc; m1.we = 1'b0; m1.adr = adr;
            m1.dat_ms = '0; m1.sel = 4'hF; m1.cti = cti; m1.bte = 2'b00;
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #2;
        sys_rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic drv_edge();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bit   found;
        int   beat;
        int   acks;
        logic m1_ack_seen;

        vt[0]  = '{1'b0, 1'b0, 1'b0, 5'b00_0_00};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 5'b00_0_00};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 5'b01_1_00};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 5'b01_1_10};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 5'b01_0_00};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 5'b00_0_00};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 5'b10_1_01};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 5'b10_0_00};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 5'b00_0_00};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 5'b01_0_00};
        vt[10] = '{1'b1, 1'b1, 1'b0, 5'b00_0_00};
`ifdef WSHB_ARB_RR_EN
        vt[11] = '{1'b1, 1'b1, 1'b1, 5'b10_1_01};
        vt[12] = '{1'b0, 1'b0, 1'b0, 5'b10_0_00};
`else
        vt[11] = '{1'b1, 1'b1, 1'b1, 5'b01_1_10};
        vt[12] = '{1'b0, 1'b0, 1'b0, 5'b01_0_00};
`endif
        vt[13] = '{1'b0, 1'b0, 1'b0, 5'b00_0_00};

        // Reset with both masters requesting
        sys_rst = 1'b1;
        drive(0, 1'b1, 32'h0, 3'b000);
        drive(1, 1'b1, 32'h0, 3'b000);
        #12;
        check("rst_outputs", {gnt, s.cyc, s.stb, m0.ack, m1.ack}, 6'b00_0000);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_first_tie", gnt, 2'b01);
        drv_edge();
        drive(0, 1'b0, 32'h0, 3'b000);
        drive(1, 1'b0, 32'h0, 3'b000);

        // Cycle-by-cycle arbitration table with a forced slave ack
        do_reset();
        force_mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drv_edge();
            drive(0, vt[i].c0, 32'h10 + i, 3'b000);
            drive(1, vt[i].c1, 32'h20 + i, 3'b000);
            tb_ack = vt[i].ack;
            @(negedge sys_clk);
            check($sformatf("vec%0d", i), {gnt, s.cyc, m0.ack, m1.ack}, vt[i].exp);
        end
        drv_edge();
        drive(0, 1'b0, 32'h0, 3'b000);
        drive(1, 1'b0, 32'h0, 3'b000);
        tb_ack = 1'b0;
        force_mode = 1'b0;

        // Single master-0 read with 3-cycle slave latency
        do_reset();
        slv_lat = 3;
        drv_edge();
        drive(0, 1'b1, 32'h100, 3'b000);
        sb_q.push_back(32'hCAFEF00D);
        @(negedge sys_clk);
        check("rd_lat_idle", s.cyc, 1'b0);
        @(negedge sys_clk);
        check("rd_lat_fwd", {s.cyc, s.stb, s.adr}, {2'b11, 32'h100});
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (s.ack) begin
                found = 1'b1;
                check("rd_ack_route", {m0.ack, m1.ack}, 2'b10);
                check("rd_data", m0.dat_sm, pop_exp());
            end
        end
        if (!found) check("rd_timeout", 1'b0, 1'b1);
        drv_edge();
        drive(0, 1'b0, 32'h0, 3'b000);

        // Master 1 requests during an 8-beat master 0 burst
        do_reset();
        slv_lat = 1;
        drv_edge();
        drive(0, 1'b1, 32'h200, 3'b010);
        for (int i = 0; i < 8; i++) sb_q.push_back(data_for(32'h200 + 4 * i));
        drv_edge();
        drive(1, 1'b1, 32'h300, 3'b000);
        sb_q.push_back(data_for(32'h300));
        beat = 0;
        m1_ack_seen = 1'b0;
        for (int k = 0; k < 100 && beat < 8; k++) begin
            @(negedge sys_clk);
            if (m1.ack) m1_ack_seen = 1'b1;
            if (m0.ack) begin
                check($sformatf("burst_beat%0d", beat), m0.dat_sm, pop_exp());
                beat++;
                drv_edge();
                if (beat < 8) drive(0, 1'b1, 32'h200 + 4 * beat, (beat == 7) ? 3'b111 : 3'b010);
                else          drive(0, 1'b0, 32'h0, 3'b000);
            end
        end
        check("burst_beats", beat, 8);
        check("burst_m1_stalled", m1_ack_seen, 1'b0);
        @(negedge sys_clk);
        check("hoff_release", {gnt, s.cyc}, 3'b01_0);
        @(negedge sys_clk);
        check("hoff_gap", {gnt, s.cyc}, 3'b00_0);
        @(negedge sys_clk);
        check("hoff_gnt1", {gnt, s.cyc, s.adr}, {3'b10_1, 32'h300});
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (m1.ack) begin
                found = 1'b1;
                check("hoff_m1_data", m1.dat_sm, pop_exp());
            end
        end
        if (!found) check("hoff_m1_timeout", 1'b0, 1'b1);
        drv_edge();
        drive(1, 1'b0, 32'h0, 3'b000);

        // Asynchronous reset during beat 3 of a master 1 burst
        do_reset();
        slv_lat = 1;
        drv_edge();
        drive(1, 1'b1, 32'h400, 3'b010);
        acks = 0;
        for (int k = 0; k < 50 && acks < 2; k++) begin
            @(negedge sys_clk);
            if (m1.ack) begin
                acks++;
                drv_edge();
                drive(1, 1'b1, 32'h400 + 4 * acks, 3'b010);
            end
        end
        check("mid_beats", acks, 2);
        #2;
        check("mid_pre_rst", {gnt, s.cyc, s.stb}, 4'b10_11);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_drop", {gnt, s.cyc, s.stb}, 4'b00_00);
        drive(1, 1'b0, 32'h0, 3'b000);
        sb_q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        drv_edge();
        drive(1, 1'b1, 32'h500, 3'b000);
        sb_q.push_back(data_for(32'h500));
        @(negedge sys_clk);
        check("post_rst_lat0", {gnt, s.cyc}, 3'b00_0);
        @(negedge sys_clk);
        check("post_rst_lat1", {gnt, s.cyc}, 3'b10_1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (m1.ack) begin
                found = 1'b1;
                check("post_rst_data", m1.dat_sm, pop_exp());
            end
        end
        if (!found) check("post_rst_timeout", 1'b0, 1'b1);
        drv_edge();
        drive(1, 1'b0, 32'h0, 3'b000);
        repeat (2) @(posedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
